// File: rtl/loop_down_counter_if.sv
// Handshake/status bundle between the loop controller and the down-counter.
interface loop_down_counter_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dec;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             zero;
  logic             done;
  logic             underflow;

  // Controller side: issues loads and decrements, observes count status.
  modport master (
    output load, load_val, dec,
    input  out, busy, zero, done, underflow
  );

  // Counter side: consumes commands, reports count status.
  modport slave (
    input  load, load_val, dec,
    output out, busy, zero, done, underflow
  );

endinterface

// File: rtl/loop_down_counter.sv
// Loadable down-counter with IDLE/RUN/EXPIRED control FSM used to terminate
// iteration loops. State updates on the falling clock edge to line up with
// the other address counters. Optional auto-reload restarts the count from
// the last loaded trip count on expiry.
module loop_down_counter #(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  loop_down_counter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             underflow_q, underflow_d;

  // Next-state and next-output logic: load beats dec; dec outside RUN is an error.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    reload_d    = reload_q;
    done_d      = 1'b0;
    underflow_d = underflow_q;

    if (bus.load) begin
      reload_d    = bus.load_val;
      underflow_d = 1'b0;
      if (bus.load_val != CNT_ZERO) begin
        out_d   = bus.load_val;
        state_d = ST_RUN;
      end else begin
        // A zero trip count expires immediately.
        out_d   = CNT_ZERO;
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end
    end else if (bus.dec) begin
      case (state_q)
        ST_RUN: begin
          if (out_q > CNT_ONE) begin
            out_d = out_q - CNT_ONE;
          end else begin
            done_d = 1'b1;
            if (AUTO_RELOAD) begin
              // reload_q is non-zero here: RUN is only entered by a non-zero load.
              out_d   = reload_q;
              state_d = ST_RUN;
            end else begin
              out_d   = CNT_ZERO;
              state_d = ST_EXPIRED;
            end
          end
        end
        ST_IDLE, ST_EXPIRED: begin
          // No active count: hold at zero rather than wrap, flag the error.
          out_d       = CNT_ZERO;
          underflow_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
      out_d   = out_q;
    end

    busy_d = (state_d == ST_RUN);
    zero_d = (out_d == CNT_ZERO);
  end

  // Falling-edge state register with synchronous active-high reset.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= CNT_ZERO;
      reload_q    <= CNT_ZERO;
      busy_q      <= 1'b0;
      zero_q      <= 1'b1;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      reload_q    <= reload_d;
      busy_q      <= busy_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
  assign bus.zero      = zero_q;
  assign bus.done      = done_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_loop_down_counter.sv
// Bench for loop_down_counter: drives one stimulus stream into a stop-on-expiry
// instance and an auto-reload instance and compares both against a
// trip-count model of the loop semantics.
module tb_loop_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_s = 1'b0;
  logic [7:0] load_val_s = 8'd0;
  logic       dec_s = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state, index 0 = AUTO_RELOAD 0, index 1 = AUTO_RELOAD 1.
  int m_cnt [2];
  int m_rel [2];
  bit m_run [2];
  bit m_uf  [2];
  bit m_done[2];

  loop_down_counter_if #(.WIDTH(8)) if0 ();
  loop_down_counter_if #(.WIDTH(8)) if1 ();

  assign if0.load = load_s;  assign if0.load_val = load_val_s;  assign if0.dec = dec_s;
  assign if1.load = load_s;  assign if1.load_val = load_val_s;  assign if1.dec = dec_s;

  loop_down_counter #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  loop_down_counter #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  wire [11:0] obs0 = {if0.out, if0.busy, if0.zero, if0.done, if0.underflow};
  wire [11:0] obs1 = {if1.out, if1.busy, if1.zero, if1.done, if1.underflow};

  // One loop iteration step of the reference: trip count left, running flag, error flag.
  function automatic void model_step(int i, bit rst, bit ld, int lv, bit d);
    m_done[i] = 1'b0;
    if (rst) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 1'b0; m_uf[i] = 1'b0;
    end else if (ld) begin
      m_rel[i] = lv; m_uf[i] = 1'b0; m_cnt[i] = lv;
      m_run[i] = (lv != 0);
      m_done[i] = (lv == 0);
    end else if (d) begin
      if (m_run[i]) begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          m_done[i] = 1'b1;
          if (i == 1) m_cnt[i] = m_rel[i];
          else m_run[i] = 1'b0;
        end
      end else begin
        m_uf[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [11:0] exp_vec(int i);
    logic [31:0] c;
    c = m_cnt[i];
    return {c[7:0], m_run[i], (m_cnt[i] == 0), m_done[i], m_uf[i]};
  endfunction

  // Drive one cycle of inputs after the rising edge, update the model, sample after the falling edge.
  task automatic apply(input bit rst, input bit ld, input logic [7:0] lv, input bit d);
    @(posedge clk);
    reset = rst; load_s = ld; load_val_s = lv; dec_s = d;
    model_step(0, rst, ld, int'(lv), d);
    model_step(1, rst, ld, int'(lv), d);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 8'd0, 1'b0);
    apply(1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (((i == 0) ? obs0 : obs1) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h expected %h", i, (i == 0) ? obs0 : obs1, exp_vec(i));
      end
    end
    n_cmp++;
    if (obs0 !== 12'h004) begin
      n_fail++;
      $display("FAIL reset_const: got %h expected %h", obs0, 12'h004);
    end
    apply(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_basic_count();
    logic [7:0] exp_out [4];
    exp_out = '{8'd3, 8'd2, 8'd1, 8'd0};
    for (int k = 0; k < 4; k++) begin
      if (k == 0) apply(1'b0, 1'b1, 8'd3, 1'b0);
      else        apply(1'b0, 1'b0, 8'd0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (((i == 0) ? obs0 : obs1) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL count step%0d dut%0d: got %h expected %h", k, i, (i == 0) ? obs0 : obs1, exp_vec(i));
        end
      end
      n_cmp++;
      if (if0.out !== exp_out[k] || if0.done !== (k == 3) || if0.busy !== (k != 3) || if0.zero !== (k == 3)) begin
        n_fail++;
        $display("FAIL count_const step%0d: got out=%0d done=%b busy=%b zero=%b expected out=%0d",
                 k, if0.out, if0.done, if0.busy, if0.zero, exp_out[k]);
      end
    end
  endtask

  task automatic test_underflow();
    apply(1'b0, 1'b0, 8'd0, 1'b1);
    apply(1'b0, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if (if0.underflow !== 1'b1 || if0.out !== 8'd0 || if0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_set: got uf=%b out=%0d done=%b expected uf=1 out=0 done=0",
               if0.underflow, if0.out, if0.done);
    end
    apply(1'b0, 1'b1, 8'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (((i == 0) ? obs0 : obs1) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL underflow_clear dut%0d: got %h expected %h", i, (i == 0) ? obs0 : obs1, exp_vec(i));
      end
    end
  endtask

  task automatic test_priority();
    apply(1'b0, 1'b1, 8'd4, 1'b1);
    n_cmp++;
    if (if0.out !== 8'd4 || if1.out !== 8'd4) begin
      n_fail++;
      $display("FAIL load_beats_dec: got %0d/%0d expected 4", if0.out, if1.out);
    end
    apply(1'b1, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if (if0.out !== 8'd0 || if0.busy !== 1'b0 || if0.done !== 1'b0 || if1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_beats_dec: got out=%0d busy=%b done=%b/%b expected 0,0,0/0",
               if0.out, if0.busy, if0.done, if1.done);
    end
    apply(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_load_zero();
    apply(1'b0, 1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (((i == 0) ? obs0 : obs1) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL load_zero dut%0d: got %h expected %h", i, (i == 0) ? obs0 : obs1, exp_vec(i));
      end
    end
    n_cmp++;
    if (obs1 !== 12'h006) begin
      n_fail++;
      $display("FAIL load_zero_const: got %h expected %h", obs1, 12'h006);
    end
    apply(1'b0, 1'b0, 8'd0, 1'b0);
    n_cmp++;
    if (if0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_zero_single: got done=%b expected 0", if0.done);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] seq [6];
    seq = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    apply(1'b0, 1'b1, 8'd2, 1'b0);
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if (if1.out !== seq[k] || if1.done !== (k % 2 == 1) || if1.busy !== 1'b1 || if1.zero !== 1'b0) begin
        n_fail++;
        $display("FAIL auto_reload dec%0d: got out=%0d done=%b busy=%b zero=%b expected out=%0d done=%b",
                 k + 1, if1.out, if1.done, if1.busy, if1.zero, seq[k], (k % 2 == 1));
      end
    end
    // Reload value 1: every dec is an expiry, so done stays high back to back.
    apply(1'b0, 1'b1, 8'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 8'd0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (((i == 0) ? obs0 : obs1) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL reload_one dec%0d dut%0d: got %h expected %h", k, i, (i == 0) ? obs0 : obs1, exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_full_range();
    int dones = 0;
    apply(1'b0, 1'b1, 8'd255, 1'b0);
    for (int k = 1; k <= 255; k++) begin
      apply(1'b0, 1'b0, 8'd0, 1'b1);
      if (if0.done === 1'b1) dones++;
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (((i == 0) ? obs0 : obs1) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL full_range dec%0d dut%0d: got %h expected %h", k, i, (i == 0) ? obs0 : obs1, exp_vec(i));
        end
      end
    end
    n_cmp++;
    if (dones != 1 || if0.done !== 1'b1 || if0.out !== 8'd0 || if0.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_range_end: got dones=%0d done=%b out=%0d uf=%b expected 1,1,0,0",
               dones, if0.done, if0.out, if0.underflow);
    end
    apply(1'b0, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if (if0.underflow !== 1'b1 || if0.out !== 8'd0 || if0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_range_extra: got uf=%b out=%0d done=%b expected 1,0,0",
               if0.underflow, if0.out, if0.done);
    end
  endtask

  task automatic test_random();
    bit         r, l, d;
    logic [7:0] v;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 6) == 0);
      d = ($urandom_range(0, 9) < 7);
      v = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      apply(r, l, v, d);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (((i == 0) ? obs0 : obs1) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL random cyc%0d dut%0d: got %h expected %h", k, i, (i == 0) ? obs0 : obs1, exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 1'b0; m_uf[i] = 1'b0; m_done[i] = 1'b0;
    end
    test_reset();
    test_basic_count();
    test_underflow();
    test_priority();
    test_load_zero();
    test_auto_reload();
    test_full_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_down_counter.md
Name: loop_down_counter

Overview:
- Loadable down-counter with a small control FSM that terminates the processor's iteration loops (pixel, row and stride loops) during downsampling.
- It works in the opposite direction to the processor's incrementing address counters. The controller loads a trip count, pulses `dec` once per iteration, and receives a one-cycle `done` pulse when the count expires.
- Optional auto-reload supports nested and repeating loops without controller reloads.

Parameters:
- WIDTH, 8, counter and load-value width in bits.
- AUTO_RELOAD, 0, 1 = on expiry, reload the last loaded value and keep running; 0 = stop in EXPIRED.

Ports:
- clk  input  1  system clock; all state updates on the falling edge, as for the processor's other counters
- reset  input  1  synchronous, active-high reset
- load  input  1  capture load_val as the new count
- load_val  input  WIDTH  trip count to load
- dec  input  1  decrement request, one iteration per asserted cycle
- out  output  WIDTH  current remaining count
- busy  output  1  high while in RUN
- zero  output  1  high when out == 0
- done  output  1  one-cycle pulse when the count reaches 0 through dec, or on load of 0
- underflow  output  1  sticky error: dec received while no count was active

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- All outputs are registered and update only on the negedge of `clk`. The power-up initial state equals the reset state.
- Reset (sampled at the edge, highest priority): state = IDLE, out = 0, reload register = 0, busy = 0, zero = 1, done = 0, underflow = 0. Reset mid-count abandons the count with no done pulse.
- FSM states:
  - IDLE: no count loaded.
  - RUN: out > 0.
  - EXPIRED: count finished, out = 0.
- Priority within a cycle: reset > load > dec.
- load = 1, from any state:
  - reload register <= load_val and underflow <= 0.
  - If load_val != 0: out <= load_val and state <= RUN.
  - If load_val == 0: out <= 0, state <= EXPIRED and done pulses.
  - Any simultaneous dec is ignored.
- RUN, dec = 1, out > 1: out <= out - 1.
- RUN, dec = 1, out == 1:
  - done pulses on the same edge.
  - If AUTO_RELOAD = 0: out <= 0 and state <= EXPIRED.
  - If AUTO_RELOAD = 1: out <= reload register and state stays RUN. zero never asserts in this case.
- RUN, dec = 0: hold.
- IDLE or EXPIRED, dec = 1 (without load):
  - out stays 0, with no wrap to all-ones.
  - underflow <= 1 and stays set until the next load or reset.
  - No done pulse.
- done is high for exactly one cycle per expiry. It is never high two cycles in a row unless consecutive expiries occur, e.g. load of 1 followed by dec with AUTO_RELOAD = 1 and reload value 1.
- Output decoding: busy = (state == RUN), zero = (out == 0). Both are derived from registered state, so there is no combinational path from the inputs.
- Latency: load or dec at edge N is visible on out, busy, zero and done immediately after edge N.
- Width: arithmetic is modulo 2^WIDTH but never wraps. A load of 2^WIDTH-1 takes exactly 2^WIDTH-1 dec pulses to expire.

Test Plan:
- Reset, then load = 1, load_val = 3; then dec for 3 cycles (AUTO_RELOAD = 0) -> out 3, 2, 1, 0; done high only after the third dec; busy drops and zero rises on that same edge; state EXPIRED.
- After expiry, dec twice -> out stays 0, underflow = 1 and held, no done pulse. Then load 5 -> underflow clears and out = 5.
- Load 4 and dec on the same cycle -> out = 4 (load wins). Next cycle, reset asserted together with dec -> out = 0, busy = 0, no done pulse.
- Load 0 -> done pulses once, zero = 1, busy = 0, state EXPIRED.
- AUTO_RELOAD = 1, load 2, then 6 consecutive dec cycles -> out 1, 2, 1, 2, 1, 2; done pulses after decs 2, 4 and 6; busy stays 1 throughout.
- WIDTH = 8, load 255, dec 255 times -> done fires exactly once on the 255th dec, out = 0, underflow = 0; a further dec sets underflow and out remains 0.
